// File: rtl/bullet_hit_scanner.sv
// Purpose: per-frame walk of the bullet list that clears bullets hitting live enemy boxes.
// Latency: 2 cycles per entry (WAIT, CHECK); done 2*min(N+1,DEPTH) cycles after start.
// Backpressure: none; the memory read port must answer in one cycle, and start is ignored while busy.
module bullet_hit_scanner #(
   parameter int DEPTH   = 64,
   parameter int SIZE    = 32,
   parameter int ENEMIES = 4,
   parameter int ENEMY_W = 32,
   parameter int ENEMY_H = 32,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   output logic [AW-1:0]           rd_addr,
   input  logic [23:0]             rd_data,
   output logic                    wr_en,
   output logic [AW-1:0]           wr_addr,
   output logic [23:0]             wr_data,
   input  logic [12*ENEMIES-1:0]   enemy_x,
   input  logic [11*ENEMIES-1:0]   enemy_y,
   input  logic [ENEMIES-1:0]      enemy_alive,
   output logic [ENEMIES-1:0]      hit_mask,
   output logic [7:0]              hit_count,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [AW-1:0]        rd_addr_q, rd_addr_d;
   logic [AW-1:0]        wr_addr_q, wr_addr_d;
   logic                 wr_en_q, wr_en_d;
   logic [ENEMIES-1:0]   hit_mask_q, hit_mask_d;
   logic [7:0]           hit_count_q, hit_count_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   // Widened bullet coordinates so edge sums never wrap.
   logic [12:0]          bx;
   logic [11:0]          by;
   logic [ENEMIES-1:0]   overlap;
   logic [ENEMIES-1:0]   cand;
   logic [ENEMIES-1:0]   pick;

   assign bx = {1'b0, rd_data[12:1]};
   assign by = {1'b0, rd_data[23:13]};

   // Box-overlap test of the current bullet against every enemy in parallel.
   always_comb begin
      overlap = '0;
      for (int i = 0; i < ENEMIES; i++) begin
         overlap[i] = (bx < ({1'b0, enemy_x[12*i +: 12]} + 13'(ENEMY_W))) &&
                      ({1'b0, enemy_x[12*i +: 12]} < (bx + 13'(SIZE))) &&
                      (by < ({1'b0, enemy_y[11*i +: 11]} + 12'(ENEMY_H))) &&
                      ({1'b0, enemy_y[11*i +: 11]} < (by + 12'(SIZE)));
      end
   end

   // Only live enemies not yet struck this scan are candidates; lowest index wins.
   assign cand = overlap & enemy_alive & ~hit_mask_q;
   assign pick = cand & (~cand + ENEMIES'(1));

   // Next-state and output computation for the scan sequencer.
   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      wr_addr_d   = wr_addr_q;
      wr_en_d     = 1'b0;
      hit_mask_d  = hit_mask_q;
      hit_count_d = hit_count_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               rd_addr_d  = '0;
               hit_mask_d = '0;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (!rd_data[0]) begin
               // First invalid entry terminates the compacted list.
               state_d = S_DONE;
            end else begin
               if (|cand) begin
                  hit_mask_d = hit_mask_q | pick;
                  if (hit_count_q != 8'hFF) begin
                     hit_count_d = hit_count_q + 8'd1;
                  end
                  wr_en_d   = 1'b1;
                  wr_addr_d = rd_addr_q;
               end
               if (rd_addr_q == AW'(DEPTH - 1)) begin
                  state_d = S_DONE;
               end else begin
                  rd_addr_d = rd_addr_q + AW'(1);
                  state_d   = S_WAIT;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and registered outputs; reset aborts a scan immediately.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         rd_addr_q   <= '0;
         wr_addr_q   <= '0;
         wr_en_q     <= 1'b0;
         hit_mask_q  <= '0;
         hit_count_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         wr_addr_q   <= wr_addr_d;
         wr_en_q     <= wr_en_d;
         hit_mask_q  <= hit_mask_d;
         hit_count_q <= hit_count_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign rd_addr   = rd_addr_q;
   assign wr_addr   = wr_addr_q;
   assign wr_en     = wr_en_q;
   assign wr_data   = 24'h0;
   assign hit_mask  = hit_mask_q;
   assign hit_count = hit_count_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_bullet_hit_scanner.sv
// Purpose: directed and randomized checks of bullet_hit_scanner against a list-walking model.
// Latency: checks scan length, write stream, mask, count and final memory image per scan.
// Backpressure: the bench memory answers every read one cycle after the address.
`define CHK(tag, obs, exp) \
   begin \
      checks++; \
      assert ((obs) === (exp)) else begin \
         fails++; \
         $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); \
      end \
   end

module tb_bullet_hit_scanner;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [5:0]    rd_addr;
   logic [23:0]   rd_data;
   logic          wr_en;
   logic [5:0]    wr_addr;
   logic [23:0]   wr_data;
   logic [47:0]   enemy_x;
   logic [43:0]   enemy_y;
   logic [3:0]    enemy_alive;
   logic [3:0]    hit_mask;
   logic [7:0]    hit_count;
   logic          busy;
   logic          done;

   int            checks = 0;
   int            fails  = 0;

   logic [11:0]   ex [4];
   logic [10:0]   ey [4];
   logic [23:0]   mem [64];
   logic [23:0]   img [64];
   logic          ld_go = 1'b0;
   int            m_cnt = 0;

   always #5 clock = ~clock;

   bullet_hit_scanner dut (
      .clock(clock), .reset(reset), .start(start),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_alive(enemy_alive),
      .hit_mask(hit_mask), .hit_count(hit_count), .busy(busy), .done(done)
   );

   always_comb begin
      enemy_x = '0;
      enemy_y = '0;
      for (int i = 0; i < 4; i++) begin
         enemy_x[12*i +: 12] = ex[i];
         enemy_y[11*i +: 11] = ey[i];
      end
   end

   // Bullet memory: one-cycle read latency, clearing writes, bulk image load.
   always @(posedge clock) begin
      rd_data <= mem[rd_addr];
      if (ld_go) begin
         for (int a = 0; a < 64; a++) mem[a] <= img[a];
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   function automatic logic [23:0] ent(input int x, input int y);
      logic [23:0] e;
      e = {y[10:0], x[11:0], 1'b1};
      return e;
   endfunction

   task automatic load_img();
      @(negedge clock);
      ld_go = 1'b1;
      @(negedge clock);
      ld_go = 1'b0;
   endtask

   task automatic clear_img();
      for (int a = 0; a < 64; a++) img[a] = 24'h0;
   endtask

   // Reference: walk the image and apply the hit rules with plain integers.
   task automatic run_scan(input bit start_in_done);
      logic [23:0] exp_mem [64];
      int          exp_wr[$];
      int          obs_wr[$];
      logic [3:0]  m_mask;
      int          n, exp_cyc, cyc, mism, bx, by, exi, eyi;
      bit          got_done;
      m_mask = 4'h0;
      n = 0;
      for (int a = 0; a < 64; a++) exp_mem[a] = img[a];
      for (int a = 0; a < 64; a++) begin
         if (!img[a][0]) break;
         n++;
         bx = int'(img[a][12:1]);
         by = int'(img[a][23:13]);
         for (int j = 0; j < 4; j++) begin
            exi = int'(ex[j]);
            eyi = int'(ey[j]);
            if (enemy_alive[j] && !m_mask[j] &&
                bx < exi + 32 && exi < bx + 32 && by < eyi + 32 && eyi < by + 32) begin
               m_mask[j] = 1'b1;
               if (m_cnt < 255) m_cnt++;
               exp_wr.push_back(a);
               exp_mem[a] = 24'h0;
               break;
            end
         end
      end
      exp_cyc = 2 * ((n + 1 < 64) ? n + 1 : 64);

      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      `CHK("busy_after_start", busy, 1'b1)
      got_done = 1'b0;
      cyc = 0;
      for (int c = 1; c <= 300; c++) begin
         @(posedge clock);
         #1;
         if (wr_en) begin
            obs_wr.push_back(int'(wr_addr));
            `CHK("wr_data_zero", wr_data, 24'h0)
         end
         if (done) begin
            got_done = 1'b1;
            cyc = c;
            break;
         end
      end
      `CHK("done_seen", got_done, 1'b1)
      `CHK("scan_cycles", cyc, exp_cyc)
      `CHK("hit_mask", hit_mask, m_mask)
      `CHK("hit_count", hit_count, 8'(m_cnt))
      `CHK("busy_in_done", busy, 1'b1)
      `CHK("rd_addr_end", rd_addr, 6'((n < 63) ? n : 63))
      `CHK("num_writes", obs_wr.size(), exp_wr.size())
      for (int k = 0; k < exp_wr.size() && k < obs_wr.size(); k++) begin
         `CHK("wr_addr", obs_wr[k], exp_wr[k])
      end
      if (start_in_done) start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      `CHK("done_pulse_end", done, 1'b0)
      `CHK("busy_idle", busy, 1'b0)
      @(posedge clock);
      #1;
      `CHK("still_idle", busy, 1'b0)
      mism = 0;
      for (int a = 0; a < 64; a++) if (mem[a] !== exp_mem[a]) mism++;
      `CHK("mem_image", mism, 0)
   endtask

   task automatic rand_scan();
      int n, k, x, y;
      enemy_alive = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
         ex[i] = 12'($urandom_range(0, 600));
         ey[i] = 11'($urandom_range(0, 400));
      end
      n = ($urandom_range(0, 9) == 0) ? 64 : int'($urandom_range(0, 20));
      for (int a = 0; a < 64; a++) begin
         if (a < n) begin
            if ($urandom_range(0, 3) != 0) begin
               k = int'($urandom_range(0, 3));
               x = int'(ex[k]) + int'($urandom_range(0, 80)) - 40;
               y = int'(ey[k]) + int'($urandom_range(0, 80)) - 40;
               if (x < 0) x = 0;
               if (y < 0) y = 0;
            end else begin
               x = int'($urandom_range(0, 4095));
               y = int'($urandom_range(0, 2047));
            end
            img[a] = ent(x, y);
         end else if (a == n) begin
            img[a] = 24'($urandom) & 24'hFFFFFE;
         end else begin
            img[a] = 24'($urandom);
         end
      end
      load_img();
      run_scan($urandom_range(0, 1) == 1);
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      enemy_alive = 4'h0;
      for (int i = 0; i < 4; i++) begin ex[i] = '0; ey[i] = '0; end
      clear_img();
      load_img();
      #1;
      `CHK("rst_rd_addr", rd_addr, 6'h0)
      `CHK("rst_wr_en", wr_en, 1'b0)
      `CHK("rst_wr_addr", wr_addr, 6'h0)
      `CHK("rst_busy", busy, 1'b0)
      `CHK("rst_done", done, 1'b0)
      `CHK("rst_mask", hit_mask, 4'h0)
      `CHK("rst_count", hit_count, 8'h0)
      @(negedge clock);
      reset = 1'b1;

      // Empty list.
      clear_img();
      load_img();
      run_scan(1'b0);

      // Single hit on enemy0.
      ex[0] = 12'd210; ey[0] = 11'd90; enemy_alive = 4'b0001;
      img[0] = ent(200, 100);
      load_img();
      run_scan(1'b0);

      // Two bullets over enemy1 only: second one survives.
      clear_img();
      ex[0] = 12'd1000; ey[0] = 11'd1000;
      ex[1] = 12'd300;  ey[1] = 11'd300; enemy_alive = 4'b0011;
      img[0] = ent(305, 310);
      img[1] = ent(295, 290);
      load_img();
      run_scan(1'b1);

      // Dead enemy0 overlapping, live enemy2 takes the hit.
      clear_img();
      ex[0] = 12'd50; ey[0] = 11'd50;
      ex[2] = 12'd60; ey[2] = 11'd60; enemy_alive = 4'b0100;
      img[0] = ent(55, 55);
      load_img();
      run_scan(1'b0);

      // Edge adjacency: touching is no overlap, one pixel in is a hit.
      clear_img();
      ex[0] = 12'd32; ey[0] = 11'd100; enemy_alive = 4'b0001;
      img[0] = ent(0, 100);
      load_img();
      run_scan(1'b0);
      ex[0] = 12'd31;
      load_img();
      run_scan(1'b0);

      // Full list, nobody alive.
      enemy_alive = 4'b0000;
      for (int a = 0; a < 64; a++) img[a] = ent(a * 7, a * 3);
      load_img();
      run_scan(1'b0);

      // Full list again, reset at cycle 40.
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (40) @(posedge clock);
      #2 reset = 1'b0;
      #1;
      m_cnt = 0;
      `CHK("mid_rst_rd_addr", rd_addr, 6'h0)
      `CHK("mid_rst_wr_en", wr_en, 1'b0)
      `CHK("mid_rst_wr_addr", wr_addr, 6'h0)
      `CHK("mid_rst_busy", busy, 1'b0)
      `CHK("mid_rst_done", done, 1'b0)
      `CHK("mid_rst_mask", hit_mask, 4'h0)
      `CHK("mid_rst_count", hit_count, 8'h0)
      for (int c = 0; c < 4; c++) begin
         @(posedge clock);
         #1;
         `CHK("rst_hold_done", done, 1'b0)
      end
      @(negedge clock);
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      `CHK("post_rst_idle", busy, 1'b0)

      // Randomized scans.
      for (int s = 0; s < 60; s++) rand_scan();

      // Four hits per scan until the counter saturates.
      clear_img();
      enemy_alive = 4'hF;
      for (int k = 0; k < 4; k++) begin
         ex[k] = 12'(100 * k + 100);
         ey[k] = 11'd100;
      end
      for (int s = 0; s < 70; s++) begin
         for (int k = 0; k < 4; k++) img[k] = ent(100 * k + 100, 100);
         img[4] = 24'h0;
         load_img();
         run_scan(1'b0);
      end
      `CHK("count_saturated", hit_count, 8'hFF)

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/bullet_hit_scanner.md
# bullet_hit_scanner

Collision reader for the player bullet list. Once per frame, after the bullet engine finishes its move pass, it walks the bullet memory from address 0 and compares each valid entry against a small set of enemy boxes. For every hit it writes a cleared entry back to the bullet memory and records which enemy was struck. It sits between the bullet engine's second memory port and the enemy/score logic.

## Interface
- DEPTH, 64: bullet memory entries; address width is 6 bits.
- SIZE, 32: bullet box edge, in pixels.
- ENEMIES, 4: number of enemy targets.
- ENEMY_W, 32: enemy box width, in pixels.
- ENEMY_H, 32: enemy box height, in pixels.
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low; 0 resets the block.
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- rd_addr  out  6  bullet memory read address (registered).
- rd_data  in  24  bullet entry {y[10:0], x[11:0], valid}; valid one cycle after rd_addr changes.
- wr_en  out  1  bullet memory write strobe, one cycle per hit.
- wr_addr  out  6  write address.
- wr_data  out  24  write data; always 24'h0.
- enemy_x  in  12*ENEMIES  top-left x of each enemy, enemy i at bits [12i+11:12i].
- enemy_y  in  11*ENEMIES  top-left y of each enemy.
- enemy_alive  in  ENEMIES  enemy i is a target only when its bit is 1.
- hit_mask  out  ENEMIES  enemies hit during the last or current scan.
- hit_count  out  8  total hits, saturating at 255.
- busy  out  1  high from the start acceptance through the end of DONE.
- done  out  1  one-cycle pulse marking the end of a scan.

## Operation
- States: IDLE, WAIT, CHECK, DONE.
- IDLE:
  - start=1 → rd_addr<=0, hit_mask<=0, busy<=1, next state WAIT.
  - start is ignored in every other state.
- WAIT: one RAM latency cycle; next state CHECK.
- CHECK evaluates rd_data:
  - rd_data[0]=0: end of the compacted list, go to DONE.
  - Otherwise compute each enemy's overlap. Take bx=rd_data[12:1] and by=rd_data[23:13], and enemy i's ex, ey. Overlap holds when bx < ex+ENEMY_W and ex < bx+SIZE and by < ey+ENEMY_H and ey < by+SIZE.
  - Evaluate all sums at 13 bits (x) and 12 bits (y) so they never wrap.
  - Candidate set = overlap & enemy_alive & ~hit_mask. If it is non-empty, take the lowest-index enemy j:
    - hit_mask[j]<=1;
    - hit_count<=hit_count+1, unless it is already 255;
    - wr_en<=1, wr_addr<=rd_addr, wr_data<=0.
  - A bullet kills at most one enemy, and an enemy is hit at most once per scan. A bullet that only overlaps already-hit enemies is left untouched.
  - If rd_addr==DEPTH-1, go to DONE. Otherwise rd_addr<=rd_addr+1 and go to WAIT. rd_addr never wraps.
- DONE: done=1 for one cycle, busy<=0, next state IDLE. hit_mask holds until the next accepted start.
- Cleared entries leave holes in the list; the bullet engine's clean pass compacts them.

## Timing
- Reset values: state IDLE; rd_addr, wr_addr and wr_data 0; wr_en, busy and done 0; hit_mask and hit_count 0.
- Reset asserted mid-scan aborts immediately: no further writes, no done.
- Per entry: 2 cycles (WAIT, CHECK).
- Scan length: with N valid leading entries, done asserts 2*min(N+1, DEPTH) cycles after the edge that accepts start.
  - Empty list: 2 cycles.
  - Full list: 128 cycles.
- wr_en is high in the cycle after the CHECK that found the hit, concurrent with the next WAIT. Write targets never exceed the current read address.
- enemy_x, enemy_y and enemy_alive must be stable while busy. They are sampled each CHECK cycle.
- A start arriving in the same cycle as done is ignored. A new scan needs start in IDLE.

## Test plan
- Empty list (addr 0 = 0), start pulse → done 2 cycles later; wr_en never high; hit_mask=0; hit_count unchanged.
- Bullet at addr 0 = {y=100, x=200, 1}, enemy0 at (210, 90) and alive → wr_en at addr 0 with data 0; hit_mask=4'b0001; hit_count=1; done at cycle 4.
- Two bullets both overlapping only enemy1 → only the first is cleared; hit_mask=4'b0010; hit_count +1.
- Bullet overlapping enemy0 (dead) and enemy2 (alive) → enemy2 hit; hit_mask=4'b0100.
- Edge adjacency: bullet x=0, enemy x=32 (touching, no overlap) → no write. Enemy x=31 → hit.
- All 64 entries valid with no enemies alive → done exactly 128 cycles after start; rd_addr stops at 63. Repeat, asserting reset low at cycle 40 → outputs return to reset values at once; no done.
